// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher (AES-128/192/256), one inverse round per clock.
// Round keys are fetched from an external expanded-key store via rk_addr/rk_data.
module aes_decrypt_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_block,
    output logic [3:0]   rk_addr,
    input  logic [0:127] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_block,
    output logic         busy
);

    localparam int NR = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
    localparam logic [3:0] NR_ADDR = 4'(NR);
    localparam logic [3:0] NR_LAST = 4'(NR - 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_decrypt_iter: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [0:127] st_q, st_d;
    logic [0:127] out_block_d;
    logic         out_valid_d;
    logic [0:127] round_core;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        end
        return o;
    endfunction

    function automatic logic [0:127] add_round_key(input logic [0:127] s, input logic [0:127] k);
        return s ^ k;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c+0) +: 8];
            a1 = s[8*(4*c+1) +: 8];
            a2 = s[8*(4*c+2) +: 8];
            a3 = s[8*(4*c+3) +: 8];
            o[8*(4*c+0) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[8*(4*c+1) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[8*(4*c+2) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[8*(4*c+3) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Shared by middle and final rounds; only the middle rounds add InvMixColumns.
    assign round_core = add_round_key(inv_sub_bytes(inv_shift_rows(st_q)), rk_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            cnt_q     <= '0;
            st_q      <= '0;
            out_block <= '0;
            out_valid <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            st_q      <= st_d;
            out_block <= out_block_d;
            out_valid <= out_valid_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        st_d        = st_q;
        out_block_d = out_block;
        out_valid_d = out_valid;
        in_ready    = 1'b0;
        rk_addr     = NR_ADDR;
        busy        = 1'b0;

        unique case (fsm_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d  = add_round_key(in_block, rk_data);
                    cnt_d = NR_LAST;
                    fsm_d = S_ROUND;
                end
            end
            S_ROUND: begin
                busy    = 1'b1;
                rk_addr = cnt_q;
                if (cnt_q != 4'd0) begin
                    st_d  = inv_mix_columns(round_core);
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_block_d = round_core;
                    out_valid_d = 1'b1;
                    fsm_d       = S_DONE;
                end
            end
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        st_d  = add_round_key(in_block, rk_data);
                        cnt_d = NR_LAST;
                        fsm_d = S_ROUND;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        // Nothing is accepted on a reset edge.
        if (rst) in_ready = 1'b0;
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: one instance each of AES-128/192/256,
// round keys from a bench-side key expansion, FIPS-197 known-answer vectors.
module tb_aes_decrypt_iter;

    localparam logic [0:127] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] PT2    = 128'hdeadbeef0123456789abcdeffedcba98;

    int n_tests;
    int n_fail;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [0:127] in_block  [3];
    logic [3:0]   rk_addr   [3];
    logic [0:127] rk_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [0:127] out_block [3];
    logic         busy      [3];
    logic [0:127] rks       [3][15];
    logic [0:127] ct2;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign rk_data[g] = rks[g][rk_addr[g]];
        aes_decrypt_iter #(.KEY_BITS(128 + 64*g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_block  (in_block[g]),
            .rk_addr   (rk_addr[g]),
            .rk_data   (rk_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_block (out_block[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Field inverse by exhaustive search.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 1; j < 256; j++) begin
            if (gmul(x, 8'(j)) == 8'h01) r = 8'(j);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = ginv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:31] sub_word(input logic [0:31] w);
        return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
    endfunction

    function automatic logic [0:127] enc_round(input logic [0:127] s, input logic [0:127] k, input bit mix);
        logic [0:127] t;
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
        o = t;
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[8*(4*c+0) +: 8];
                a1 = t[8*(4*c+1) +: 8];
                a2 = t[8*(4*c+2) +: 8];
                a3 = t[8*(4*c+3) +: 8];
                o[8*(4*c+0) +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                o[8*(4*c+1) +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                o[8*(4*c+2) +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                o[8*(4*c+3) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        return o ^ k;
    endfunction

    task automatic expand(input int g);
        int           nk;
        int           nr;
        logic [0:31]  w [60];
        logic [0:31]  t;
        logic [7:0]   rc;
        nk = 4 + 2*g;
        nr = 10 + 2*g;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[8:31], t[0:7]}) ^ {rc, 24'h000000};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 15; r++)
            rks[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [0:127] encrypt(input logic [0:127] pt, input int g);
        logic [0:127] s;
        int           nr;
        nr = 10 + 2*g;
        s  = pt ^ rks[g][0];
        for (int r = 1; r < nr; r++) s = enc_round(s, rks[g][r], 1'b1);
        return enc_round(s, rks[g][nr], 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vector(input int g, input logic [0:127] ct, input logic [0:127] pt);
        int nr;
        nr = 10 + 2*g;
        in_block[g]  = ct;
        in_valid[g]  = 1'b1;
        out_ready[g] = 1'b1;
        #1;
        chk("idle_rk_addr", rk_addr[g], nr);
        chk("idle_in_ready", in_ready[g], 1);
        tick();
        in_valid[g] = 1'b0;
        in_block[g] = '0;
        chk("round_busy", busy[g], 1);
        chk("round_in_ready", in_ready[g], 0);
        for (int e = 1; e <= nr; e++) begin
            chk("rk_addr_seq", rk_addr[g], nr - e);
            chk("no_early_valid", out_valid[g], 0);
            tick();
        end
        chk("out_valid", out_valid[g], 1);
        chk("plaintext", out_block[g], pt);
        chk("done_rk_addr", rk_addr[g], nr);
        chk("done_busy", busy[g], 0);
        tick();
        chk("valid_pulse", out_valid[g], 0);
        chk("retained", out_block[g], pt);
        chk("idle_in_ready_again", in_ready[g], 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b1;
            in_block[g]  = '0;
            expand(g);
        end
        ct2 = encrypt(PT2, 0);

        // Reset state
        tick();
        tick();
        chk("reset_in_ready", in_ready[0], 0);
        chk("reset_out_valid", out_valid[0], 0);
        chk("reset_out_block", out_block[0], 0);
        chk("reset_busy", busy[0], 0);
        chk("reset_rk_addr128", rk_addr[0], 10);
        chk("reset_rk_addr256", rk_addr[2], 14);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready[0], 1);

        // Known-answer vectors for each key size
        run_vector(0, CT128, PT);
        run_vector(1, CT192, PT);
        run_vector(2, CT256, PT);

        // Backpressure, then simultaneous out and in handshakes
        out_ready[0] = 1'b0;
        in_block[0]  = CT128;
        in_valid[0]  = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (10) tick();
        chk("bp_valid", out_valid[0], 1);
        chk("bp_block", out_block[0], PT);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_block[0] = ct2;
            #1;
            chk("bp_in_ready", in_ready[0], 0);
            tick();
            chk("bp_hold_valid", out_valid[0], 1);
            chk("bp_hold_block", out_block[0], PT);
        end
        out_ready[0] = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready[0], 1);
        tick();
        in_valid[0] = 1'b0;
        chk("b2b_valid_drop", out_valid[0], 0);
        chk("b2b_busy", busy[0], 1);
        chk("b2b_retained", out_block[0], PT);
        repeat (9) tick();
        chk("b2b_not_yet", out_valid[0], 0);
        tick();
        chk("b2b_valid", out_valid[0], 1);
        chk("b2b_block", out_block[0], PT2);
        tick();
        chk("b2b_consumed", out_valid[0], 0);

        // in_valid held with a different block while busy
        in_block[0] = CT128;
        in_valid[0] = 1'b1;
        tick();
        in_block[0] = ct2;
        for (int e = 1; e <= 10; e++) begin
            if (e == 5) chk("ign_in_ready", in_ready[0], 0);
            tick();
        end
        in_valid[0] = 1'b0;
        chk("ign_valid", out_valid[0], 1);
        chk("ign_block", out_block[0], PT);
        tick();
        chk("ign_idle", out_valid[0], 0);

        // Reset on the fourth ROUND cycle
        in_block[0] = ct2;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        chk("rst_pre_busy", busy[0], 1);
        chk("rst_pre_block", out_block[0], PT);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready[0], 0);
        tick();
        chk("rst_valid", out_valid[0], 0);
        chk("rst_block", out_block[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_rk_addr", rk_addr[0], 10);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", in_ready[0], 1);
        run_vector(0, ct2, PT2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
